// File: rtl/reg_wb_arb.sv
// Writeback arbiter between the EX result path and a buffered MDU result FIFO,
// with an optional pending-write scoreboard enabled by REG_WB_SCOREBOARD_EN.
module reg_wb_arb #(
    parameter int STARVE_MAX = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [4:0]  ex_waddr,
    input  logic [31:0] ex_wdata,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_waddr,
    input  logic [31:0] mdu_wdata,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        hz_rs1,
    output logic        hz_rs2,
    output logic        hz_rd,
    output logic        reg_wen,
    output logic [4:0]  reg_waddr,
    output logic [31:0] reg_wdata
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_C = FIFO_DEPTH[PW:0];
    localparam logic [3:0] STARVE_C = STARVE_MAX[3:0];

    logic [4:0]    fifo_addr_q [FIFO_DEPTH];
    logic [4:0]    fifo_addr_d [FIFO_DEPTH];
    logic [31:0]   fifo_data_q [FIFO_DEPTH];
    logic [31:0]   fifo_data_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [3:0]    starve_q, starve_d;
    logic          reg_wen_q, reg_wen_d;
    logic [4:0]    reg_waddr_q, reg_waddr_d;
    logic [31:0]   reg_wdata_q, reg_wdata_d;

    logic          fifo_nonempty;
    logic          force_mdu;
    logic          grant_mdu;
    logic          grant_ex;
    logic          push;
    logic [4:0]    head_addr;
    logic [31:0]   head_data;

    assign fifo_nonempty = (count_q != '0);
    assign head_addr     = fifo_addr_q[rd_ptr_q];
    assign head_data     = fifo_data_q[rd_ptr_q];

    // Ready comes from the registered count only, so a same-cycle pop never opens a slot.
    assign mdu_ready = (count_q < DEPTH_C);
    assign push      = mdu_valid && mdu_ready;

    assign force_mdu = fifo_nonempty && (starve_q == STARVE_C);
    assign grant_mdu = force_mdu || (fifo_nonempty && !ex_valid);
    assign grant_ex  = !grant_mdu && ex_valid;
    assign ex_ready  = !force_mdu;

    always_comb begin
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push) begin
            fifo_addr_d[wr_ptr_q] = mdu_waddr;
            fifo_data_d[wr_ptr_q] = mdu_wdata;
            wr_ptr_d              = wr_ptr_q + 1'b1;
        end
        if (grant_mdu) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, grant_mdu})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (!fifo_nonempty || grant_mdu) begin
            starve_d = 4'd0;
        end else if (grant_ex && (starve_q != STARVE_C)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Unselected cycles keep the last address/data so the write port bus stays quiet.
    always_comb begin
        reg_wen_d   = 1'b0;
        reg_waddr_d = reg_waddr_q;
        reg_wdata_d = reg_wdata_q;
        if (grant_mdu) begin
            reg_wen_d   = (head_addr != 5'd0);
            reg_waddr_d = head_addr;
            reg_wdata_d = head_data;
        end else if (grant_ex) begin
            reg_wen_d   = (ex_waddr != 5'd0);
            reg_waddr_d = ex_waddr;
            reg_wdata_d = ex_wdata;
        end
    end

    always_ff @(posedge clk) begin
        fifo_addr_q <= fifo_addr_d;
        fifo_data_q <= fifo_data_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            starve_q    <= 4'd0;
            reg_wen_q   <= 1'b0;
            reg_waddr_q <= 5'd0;
            reg_wdata_q <= 32'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            reg_wen_q   <= reg_wen_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
        end
    end

    assign reg_wen   = reg_wen_q;
    assign reg_waddr = reg_waddr_q;
    assign reg_wdata = reg_wdata_q;

`ifdef REG_WB_SCOREBOARD_EN
    logic [31:0] busy_q, busy_d;

    // Issue is applied after the clear so a same-cycle re-issue keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (grant_mdu) begin
            busy_d[head_addr] = 1'b0;
        end
        if (iss_valid && (iss_rd != 5'd0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 32'd0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign hz_rs1 = busy_q[rs1_addr];
    assign hz_rs2 = busy_q[rs2_addr];
    assign hz_rd  = iss_valid && busy_q[iss_rd];
`else
    logic unused_sb;
    assign unused_sb = ^{iss_valid, iss_rd, rs1_addr, rs2_addr};
    assign hz_rs1 = 1'b0;
    assign hz_rs2 = 1'b0;
    assign hz_rd  = 1'b0;
`endif

endmodule

// File: tb/tb_reg_wb_arb.sv
// Directed bench for reg_wb_arb: reset, EX passthrough, starvation, FIFO full,
// scoreboard and x0 handling. Hazard expectations follow REG_WB_SCOREBOARD_EN.
module tb_reg_wb_arb;

`ifdef REG_WB_SCOREBOARD_EN
    localparam logic SB_EN = 1'b1;
`else
    localparam logic SB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ready;
    logic [4:0]  ex_waddr;
    logic [31:0] ex_wdata;
    logic        mdu_valid, mdu_ready;
    logic [4:0]  mdu_waddr;
    logic [31:0] mdu_wdata;
    logic        iss_valid;
    logic [4:0]  iss_rd, rs1_addr, rs2_addr;
    logic        hz_rs1, hz_rs2, hz_rd;
    logic        reg_wen;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;

    int tests = 0;
    int fails = 0;

    reg_wb_arb #(.STARVE_MAX(3), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_waddr(mdu_waddr), .mdu_wdata(mdu_wdata),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .hz_rs1(hz_rs1), .hz_rs2(hz_rs2), .hz_rd(hz_rd),
        .reg_wen(reg_wen), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid = 0; ex_waddr = 0; ex_wdata = 0;
        mdu_valid = 0; mdu_waddr = 0; mdu_wdata = 0;
        iss_valid = 0; iss_rd = 0; rs1_addr = 0; rs2_addr = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        ex_valid = 1; ex_waddr = 5'd31; ex_wdata = 32'hFFFF_FFFF;
        mdu_valid = 1; mdu_waddr = 5'd31; mdu_wdata = 32'hFFFF_FFFF;
        iss_valid = 1; iss_rd = 5'd31; rs1_addr = 5'd31; rs2_addr = 5'd31;
        tick(); tick();
        rst = 0; idle();
        rs1_addr = 5'd31; rs2_addr = 5'd31;
        #1;
        tests++; if (reg_wen !== 1'b0) begin fails++; $display("FAIL reset_wen got %b exp 0", reg_wen); end
        tests++; if (reg_waddr !== 5'd0) begin fails++; $display("FAIL reset_waddr got %0d exp 0", reg_waddr); end
        tests++; if (reg_wdata !== 32'd0) begin fails++; $display("FAIL reset_wdata got %h exp 0", reg_wdata); end
        tests++; if (mdu_ready !== 1'b1) begin fails++; $display("FAIL reset_mdu_ready got %b exp 1", mdu_ready); end
        tests++; if (ex_ready !== 1'b1) begin fails++; $display("FAIL reset_ex_ready got %b exp 1", ex_ready); end
        tests++; if ({hz_rs1, hz_rs2, hz_rd} !== 3'b000) begin fails++; $display("FAIL reset_hz got %b exp 000", {hz_rs1, hz_rs2, hz_rd}); end
        tick();
        tests++; if (reg_wen !== 1'b0) begin fails++; $display("FAIL reset_no_write got %b exp 0", reg_wen); end
    endtask

    task automatic test_ex_pass();
        idle();
        ex_valid = 1; ex_waddr = 5'd5; ex_wdata = 32'hDEAD_BEEF;
        #1;
        tests++; if (ex_ready !== 1'b1) begin fails++; $display("FAIL ex_ready got %b exp 1", ex_ready); end
        tick();
        idle();
        tests++; if ({reg_wen, reg_waddr, reg_wdata} !== {1'b1, 5'd5, 32'hDEAD_BEEF})
            begin fails++; $display("FAIL ex_write got %b/%0d/%h exp 1/5/deadbeef", reg_wen, reg_waddr, reg_wdata); end
        tick();
        tests++; if ({reg_wen, reg_waddr, reg_wdata} !== {1'b0, 5'd5, 32'hDEAD_BEEF})
            begin fails++; $display("FAIL ex_hold got %b/%0d/%h exp 0/5/deadbeef", reg_wen, reg_waddr, reg_wdata); end
    endtask

    task automatic test_starvation();
        idle();
        ex_valid = 1; ex_waddr = 5'd1; ex_wdata = 32'h100;
        mdu_valid = 1; mdu_waddr = 5'd7; mdu_wdata = 32'h11;
        #1;
        tests++; if (mdu_ready !== 1'b1) begin fails++; $display("FAIL starve_push_ready got %b exp 1", mdu_ready); end
        tick();
        mdu_valid = 0;
        for (int i = 0; i < 3; i++) begin
            ex_waddr = 5'(10 + i); ex_wdata = 32'(200 + i);
            #1;
            tests++; if (ex_ready !== 1'b1) begin fails++; $display("FAIL starve_ex_win%0d got %b exp 1", i, ex_ready); end
            tick();
            tests++; if ({reg_wen, reg_waddr} !== {1'b1, 5'(10 + i)})
                begin fails++; $display("FAIL starve_ex_write%0d got %b/%0d exp 1/%0d", i, reg_wen, reg_waddr, 10 + i); end
        end
        tests++; if (ex_ready !== 1'b0) begin fails++; $display("FAIL starve_force got %b exp 0", ex_ready); end
        tick();
        tests++; if ({reg_wen, reg_waddr, reg_wdata} !== {1'b1, 5'd7, 32'h11})
            begin fails++; $display("FAIL starve_mdu_write got %b/%0d/%h exp 1/7/11", reg_wen, reg_waddr, reg_wdata); end
        tests++; if (ex_ready !== 1'b1) begin fails++; $display("FAIL starve_release got %b exp 1", ex_ready); end
        tick();
        tests++; if ({reg_wen, reg_waddr} !== {1'b1, 5'd12})
            begin fails++; $display("FAIL starve_ex_retry got %b/%0d exp 1/12", reg_wen, reg_waddr); end
        idle();
        tick();
    endtask

    task automatic test_fifo_full();
        idle();
        ex_valid = 1; ex_waddr = 5'd20; ex_wdata = 32'h2020;
        mdu_valid = 1; mdu_waddr = 5'd3; mdu_wdata = 32'hAAAA_0003;
        tick();
        mdu_waddr = 5'd4; mdu_wdata = 32'hBBBB_0004;
        #1;
        tests++; if (mdu_ready !== 1'b1) begin fails++; $display("FAIL full_second_ready got %b exp 1", mdu_ready); end
        tick();
        mdu_valid = 0;
        tests++; if (mdu_ready !== 1'b0) begin fails++; $display("FAIL full_ready_c2 got %b exp 0", mdu_ready); end
        tick();
        tests++; if ({mdu_ready, ex_ready} !== 2'b01) begin fails++; $display("FAIL full_c3 got %b exp 01", {mdu_ready, ex_ready}); end
        tick();
        tests++; if ({mdu_ready, ex_ready} !== 2'b00) begin fails++; $display("FAIL full_c4 got %b exp 00", {mdu_ready, ex_ready}); end
        tick();
        tests++; if ({reg_wen, reg_waddr, reg_wdata} !== {1'b1, 5'd3, 32'hAAAA_0003})
            begin fails++; $display("FAIL full_first_drain got %b/%0d/%h exp 1/3/aaaa0003", reg_wen, reg_waddr, reg_wdata); end
        tests++; if (mdu_ready !== 1'b1) begin fails++; $display("FAIL full_ready_back got %b exp 1", mdu_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if ({reg_wen, reg_waddr} !== {1'b1, 5'd20})
                begin fails++; $display("FAIL full_ex_between%0d got %b/%0d exp 1/20", i, reg_wen, reg_waddr); end
        end
        tests++; if (ex_ready !== 1'b0) begin fails++; $display("FAIL full_second_force got %b exp 0", ex_ready); end
        tick();
        tests++; if ({reg_wen, reg_waddr, reg_wdata} !== {1'b1, 5'd4, 32'hBBBB_0004})
            begin fails++; $display("FAIL full_second_drain got %b/%0d/%h exp 1/4/bbbb0004", reg_wen, reg_waddr, reg_wdata); end
        idle();
        tick();
    endtask

    task automatic test_scoreboard();
        idle();
        iss_valid = 1; iss_rd = 5'd9;
        #1;
        tests++; if (hz_rd !== 1'b0) begin fails++; $display("FAIL sb_rd_first got %b exp 0", hz_rd); end
        tick();
        rs1_addr = 5'd9; rs2_addr = 5'd8;
        #1;
        tests++; if ({hz_rs1, hz_rs2, hz_rd} !== {SB_EN, 1'b0, SB_EN})
            begin fails++; $display("FAIL sb_busy got %b exp %b", {hz_rs1, hz_rs2, hz_rd}, {SB_EN, 1'b0, SB_EN}); end
        iss_valid = 0;
        mdu_valid = 1; mdu_waddr = 5'd9; mdu_wdata = 32'h99;
        tick();
        mdu_valid = 0;
        tests++; if (hz_rs1 !== SB_EN) begin fails++; $display("FAIL sb_before_clear got %b exp %b", hz_rs1, SB_EN); end
        tick();
        tests++; if ({hz_rs1, reg_wen, reg_waddr} !== {1'b0, 1'b1, 5'd9})
            begin fails++; $display("FAIL sb_cleared got %b/%b/%0d exp 0/1/9", hz_rs1, reg_wen, reg_waddr); end
        iss_valid = 1; iss_rd = 5'd9;
        mdu_valid = 1; mdu_waddr = 5'd9; mdu_wdata = 32'h98;
        tick();
        mdu_valid = 0;
        tick();
        iss_valid = 0;
        #1;
        tests++; if ({hz_rs1, reg_waddr, reg_wdata} !== {SB_EN, 5'd9, 32'h98})
            begin fails++; $display("FAIL sb_set_wins got %b/%0d/%h exp %b/9/98", hz_rs1, reg_waddr, reg_wdata, SB_EN); end
        rst = 1; tick(); rst = 0; idle();
    endtask

    task automatic test_x0();
        idle();
        iss_valid = 1; iss_rd = 5'd0;
        #1;
        tests++; if (hz_rd !== 1'b0) begin fails++; $display("FAIL x0_hz_rd got %b exp 0", hz_rd); end
        tick();
        iss_valid = 0;
        mdu_valid = 1; mdu_waddr = 5'd0; mdu_wdata = 32'h55;
        #1;
        tests++; if ({hz_rs1, hz_rs2, mdu_ready} !== 3'b001)
            begin fails++; $display("FAIL x0_hz_ready got %b exp 001", {hz_rs1, hz_rs2, mdu_ready}); end
        tick();
        mdu_valid = 0;
        tick();
        tests++; if (reg_wen !== 1'b0) begin fails++; $display("FAIL x0_mdu_wen got %b exp 0", reg_wen); end
        tests++; if ({mdu_ready, ex_ready} !== 2'b11) begin fails++; $display("FAIL x0_drained got %b exp 11", {mdu_ready, ex_ready}); end
        ex_valid = 1; ex_waddr = 5'd0; ex_wdata = 32'h66;
        tick();
        idle();
        tests++; if (reg_wen !== 1'b0) begin fails++; $display("FAIL x0_ex_wen got %b exp 0", reg_wen); end
    endtask

    task automatic test_reset_mid();
        idle();
        ex_valid = 1; ex_waddr = 5'd2; ex_wdata = 32'h2;
        mdu_valid = 1; mdu_waddr = 5'd12; mdu_wdata = 32'h12;
        iss_valid = 1; iss_rd = 5'd12;
        tick();
        mdu_valid = 0; iss_valid = 0;
        rst = 1;
        tick();
        rst = 0; idle();
        rs1_addr = 5'd12;
        #1;
        tests++; if ({reg_wen, mdu_ready, hz_rs1} !== 3'b010)
            begin fails++; $display("FAIL midrst_state got %b exp 010", {reg_wen, mdu_ready, hz_rs1}); end
        tick();
        tests++; if (reg_wen !== 1'b0) begin fails++; $display("FAIL midrst_discard got %b exp 0", reg_wen); end
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_ex_pass();
        test_starvation();
        test_fifo_full();
        test_scoreboard();
        test_x0();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
